instr_mem_loader: RTL and testbench

- Program loader that writes the instruction memory; the memory's fetch port only reads.
- Accepts a byte stream from the host/serial front end over a valid/ready handshake and packs each group of 4 bytes, MSB first, into a 32-bit instruction word.
- Writes each word to consecutive instruction-memory addresses from 0.
- Holds the CPU pipeline in reset-like stall (cpu_hold) until loading finishes.

---
 rtl/instr_mem_loader.sv | 118 +++++++++++
 tb/tb_instr_mem_loader.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_loader.sv
// instr_mem_loader
// Loads the instruction memory from a host byte stream. Bytes arrive over a
// valid/ready handshake. Every 4 bytes are packed MSB first into one word,
// and each word is written to the next address, starting at 0. The load
// ends after HALT_WORD is written or after the last memory address is
// written. cpu_hold keeps the CPU stalled until the load is complete.
//
// Ports
//   clk        system clock, rising edge
//   reset      asynchronous active-low reset
//   start      one-cycle pulse; begins a load from IDLE or DONE
//   in_data    stream byte
//   in_valid   in_data is valid
//   in_ready   a byte is accepted this cycle
//   wr_en      memory write strobe, one cycle per word
//   wr_addr    word address being written
//   wr_data    word being written
//   busy       load in progress (RECV or WRITE)
//   done       load complete; held until the next start or reset
//   cpu_hold   CPU stall; low only in DONE
//   word_count words written in the current or last load
//
// state | meaning
// IDLE  | waiting for the first start after reset
// RECV  | collecting bytes of the current word
// WRITE | single-cycle write strobe for the assembled word
// DONE  | load finished, CPU released, waiting for a new start
module instr_mem_loader #(
   parameter int                 DEPTH     = 2048,
   parameter int                 ADDR_W    = 11,
   parameter int                 tam       = 32,
   parameter logic [tam-1:0]     HALT_WORD = 32'hFFFFFFFF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              wr_en,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [tam-1:0]    wr_data,
   output logic              busy,
   output logic              done,
   output logic              cpu_hold,
   output logic [ADDR_W:0]   word_count
);

   typedef enum logic [1:0] {IDLE, RECV, WRITE, DONE} state_t;

   state_t         state;
   logic [1:0]     byte_cnt;
   logic [tam-1:0] shreg;
   logic [tam-1:0] next_word;

   assign next_word = {shreg[tam-9:0], in_data};

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= IDLE;
         in_ready   <= 1'b0;
         wr_en      <= 1'b0;
         wr_addr    <= '0;
         wr_data    <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         cpu_hold   <= 1'b1;
         word_count <= '0;
         byte_cnt   <= '0;
         shreg      <= '0;
      end else begin
         wr_en <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  state      <= RECV;
                  wr_addr    <= '0;
                  word_count <= '0;
                  byte_cnt   <= '0;
                  done       <= 1'b0;
                  cpu_hold   <= 1'b1;
                  busy       <= 1'b1;
                  in_ready   <= 1'b1;
               end
            end
            RECV: begin
               if (in_valid && in_ready) begin
                  shreg    <= next_word;
                  byte_cnt <= byte_cnt + 2'd1;
                  if (byte_cnt == 2'd3) begin
                     wr_data  <= next_word;
                     wr_en    <= 1'b1;
                     in_ready <= 1'b0;
                     state    <= WRITE;
                  end
               end
            end
            WRITE: begin
               word_count <= word_count + 1'b1;
               // The last address ends the load, so wr_addr never wraps to 0.
               if (wr_data == HALT_WORD || wr_addr == ADDR_W'(DEPTH - 1)) begin
                  state    <= DONE;
                  done     <= 1'b1;
                  cpu_hold <= 1'b0;
                  busy     <= 1'b0;
                  in_ready <= 1'b0;
               end else begin
                  wr_addr  <= wr_addr + 1'b1;
                  in_ready <= 1'b1;
                  state    <= RECV;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_instr_mem_loader.sv
module tb_instr_mem_loader;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start_b = 1'b0, start_s = 1'b0;
   logic [7:0]  in_data = 8'h00;
   logic        in_valid = 1'b0;

   logic        in_ready_b, wr_en_b, busy_b, done_b, cpu_hold_b;
   logic [10:0] wr_addr_b;
   logic [31:0] wr_data_b;
   logic [11:0] word_count_b;

   logic        in_ready_s, wr_en_s, busy_s, done_s, cpu_hold_s;
   logic [1:0]  wr_addr_s;
   logic [31:0] wr_data_s;
   logic [2:0]  word_count_s;

   int n_tests = 0;
   int n_fail  = 0;
   bit sel = 1'b0;
   bit mon_on = 1'b1;

   int          wa_q[$];
   logic [31:0] wd_q[$];

   always #5 clk = ~clk;

   instr_mem_loader u_big (
      .clk(clk), .reset(reset), .start(start_b), .in_data(in_data),
      .in_valid(in_valid), .in_ready(in_ready_b), .wr_en(wr_en_b),
      .wr_addr(wr_addr_b), .wr_data(wr_data_b), .busy(busy_b),
      .done(done_b), .cpu_hold(cpu_hold_b), .word_count(word_count_b));

   instr_mem_loader #(.DEPTH(4), .ADDR_W(2)) u_small (
      .clk(clk), .reset(reset), .start(start_s), .in_data(in_data),
      .in_valid(in_valid), .in_ready(in_ready_s), .wr_en(wr_en_s),
      .wr_addr(wr_addr_s), .wr_data(wr_data_s), .busy(busy_s),
      .done(done_s), .cpu_hold(cpu_hold_s), .word_count(word_count_s));

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   // Write monitor on the selected instance; the loader must not accept
   // bytes while it is strobing a write.
   always @(negedge clk) begin
      if (mon_on) begin
         if (!sel && wr_en_b) begin
            chk("rdy_in_write", {31'd0, in_ready_b}, 32'd0);
            wa_q.push_back(int'(wr_addr_b));
            wd_q.push_back(wr_data_b);
         end
         if (sel && wr_en_s) begin
            chk("rdy_in_write_s", {31'd0, in_ready_s}, 32'd0);
            wa_q.push_back(int'(wr_addr_s));
            wd_q.push_back(wr_data_s);
         end
      end
   end

   task automatic pulse_start();
      @(negedge clk);
      if (sel) start_s = 1'b1; else start_b = 1'b1;
      @(negedge clk);
      start_s = 1'b0;
      start_b = 1'b0;
   endtask

   task automatic send_bytes(input logic [7:0] b[], input int gap);
      for (int i = 0; i < b.size(); i++) begin
         int  tmo;
         logic rdy;
         in_data  = b[i];
         in_valid = 1'b1;
         tmo = 0;
         rdy = sel ? in_ready_s : in_ready_b;
         while (!rdy && tmo < 50) begin
            @(negedge clk);
            rdy = sel ? in_ready_s : in_ready_b;
            tmo++;
         end
         if (tmo >= 50) chk("send_timeout", 32'(i), 32'hFFFF);
         @(negedge clk);
         in_valid = 1'b0;
         for (int g = 0; g < gap; g++) @(negedge clk);
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_done();
      int  tmo = 0;
      logic d;
      d = sel ? done_s : done_b;
      while (!d && tmo < 20) begin
         @(negedge clk);
         d = sel ? done_s : done_b;
         tmo++;
      end
      if (tmo >= 20) chk("done_timeout", 32'd0, 32'd1);
   endtask

   task automatic check_two(input string tag, input logic [31:0] w0, input logic [31:0] w1);
      chk({tag, "_nwr"}, 32'(wa_q.size()), 32'd2);
      if (wa_q.size() == 2) begin
         chk({tag, "_a0"}, 32'(wa_q[0]), 32'd0);
         chk({tag, "_d0"}, wd_q[0], w0);
         chk({tag, "_a1"}, 32'(wa_q[1]), 32'd1);
         chk({tag, "_d1"}, wd_q[1], w1);
      end
      chk({tag, "_done"}, {31'd0, done_b}, 32'd1);
      chk({tag, "_hold"}, {31'd0, cpu_hold_b}, 32'd0);
      chk({tag, "_busy"}, {31'd0, busy_b}, 32'd0);
      chk({tag, "_cnt"}, 32'(word_count_b), 32'd2);
      chk({tag, "_addr"}, 32'(wr_addr_b), 32'd1);
   endtask

   initial begin
      logic [7:0] prog1[] = '{8'h00, 8'h21, 8'h48, 8'h21, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      logic [7:0] part[]  = '{8'h12, 8'h34};
      logic [7:0] prog2[] = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      logic [7:0] w_a[]   = '{8'h11, 8'h22, 8'h33, 8'h44};
      logic [7:0] w_h[]   = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
      logic [7:0] full[]  = '{8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02,
                              8'h00, 8'h00, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h04};
      bit rdy_seen;

      // Reset values
      #12;
      chk("rst_ready", {31'd0, in_ready_b}, 32'd0);
      chk("rst_wren",  {31'd0, wr_en_b}, 32'd0);
      chk("rst_addr",  32'(wr_addr_b), 32'd0);
      chk("rst_data",  wr_data_b, 32'd0);
      chk("rst_busy",  {31'd0, busy_b}, 32'd0);
      chk("rst_done",  {31'd0, done_b}, 32'd0);
      chk("rst_hold",  {31'd0, cpu_hold_b}, 32'd1);
      chk("rst_cnt",   32'(word_count_b), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_ready", {31'd0, in_ready_b}, 32'd0);

      // Two-word load, in_valid held high
      sel = 0; wa_q.delete(); wd_q.delete();
      pulse_start();
      chk("start_busy", {31'd0, busy_b}, 32'd1);
      chk("start_ready", {31'd0, in_ready_b}, 32'd1);
      send_bytes(prog1, 0);
      wait_done();
      check_two("load", 32'h00214821, 32'hFFFFFFFF);

      // Bytes offered in DONE are ignored
      in_data = 8'h55; in_valid = 1'b1;
      repeat (3) @(negedge clk);
      chk("done_ready", {31'd0, in_ready_b}, 32'd0);
      chk("done_nowr", 32'(wa_q.size()), 32'd2);
      in_valid = 1'b0;

      // Restart from DONE, gapped stream
      wa_q.delete(); wd_q.delete();
      pulse_start();
      chk("rst_done_d", {31'd0, done_b}, 32'd0);
      chk("rst_done_h", {31'd0, cpu_hold_b}, 32'd1);
      chk("rst_done_a", 32'(wr_addr_b), 32'd0);
      chk("rst_done_c", 32'(word_count_b), 32'd0);
      send_bytes(prog1, 3);
      wait_done();
      check_two("gap", 32'h00214821, 32'hFFFFFFFF);

      // start pulsed during RECV is ignored
      wa_q.delete(); wd_q.delete();
      pulse_start();
      send_bytes(w_a, 0);
      repeat (2) @(negedge clk);
      chk("recv_addr0", 32'(wr_addr_b), 32'd1);
      chk("recv_cnt0",  32'(word_count_b), 32'd1);
      pulse_start();
      @(negedge clk);
      chk("recv_addr1", 32'(wr_addr_b), 32'd1);
      chk("recv_cnt1",  32'(word_count_b), 32'd1);
      chk("recv_busy",  {31'd0, busy_b}, 32'd1);
      send_bytes(w_h, 0);
      wait_done();
      check_two("ign", 32'h11223344, 32'hFFFFFFFF);

      // Reset mid-word: asynchronous, between edges
      wa_q.delete(); wd_q.delete();
      pulse_start();
      send_bytes(part, 0);
      #2 reset = 1'b0;
      #1;
      chk("arst_ready", {31'd0, in_ready_b}, 32'd0);
      chk("arst_busy",  {31'd0, busy_b}, 32'd0);
      chk("arst_hold",  {31'd0, cpu_hold_b}, 32'd1);
      chk("arst_addr",  32'(wr_addr_b), 32'd0);
      @(negedge clk);
      reset = 1'b1;
      pulse_start();
      send_bytes(prog2, 0);
      wait_done();
      check_two("arst", 32'hAABBCCDD, 32'hFFFFFFFF);

      // Full memory on the 4-word instance
      sel = 1; wa_q.delete(); wd_q.delete();
      pulse_start();
      send_bytes(full, 1);
      wait_done();
      chk("full_nwr", 32'(wa_q.size()), 32'd4);
      for (int i = 0; i < wa_q.size() && i < 4; i++) begin
         chk("full_addr", 32'(wa_q[i]), 32'(i));
         chk("full_data", wd_q[i], 32'(i + 1));
      end
      chk("full_done", {31'd0, done_s}, 32'd1);
      chk("full_cnt",  32'(word_count_s), 32'd4);
      chk("full_addr_hold", 32'(wr_addr_s), 32'd3);
      rdy_seen = 0;
      in_data = 8'h05; in_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if (in_ready_s) rdy_seen = 1;
      end
      in_valid = 1'b0;
      chk("full_5th_ready", {31'd0, rdy_seen}, 32'd0);
      chk("full_5th_nowr", 32'(wa_q.size()), 32'd4);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
